// File: rtl/uart_tx_frame_if.sv
// Input-side word handshake for uart_tx_frame: source drives word and valid, transmitter returns ready.
interface uart_tx_frame_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_i;
    logic              data_i_v;
    logic              data_i_rdy;

    modport master (output data_i, data_i_v, input data_i_rdy);
    modport slave  (input data_i, data_i_v, output data_i_rdy);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// 1 or 2 stop bits, each bit held CLKS_PER_BIT clocks; valid/ready word input.
module uart_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    uart_tx_frame_if.slave in_if,
    output logic           tx_o,
    output logic           busy_o,
    output logic           done_o
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_W - 1);
    localparam logic          SBIT_LAST = (STOP_BITS == 2);

    generate
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
            $error("uart_tx_frame: DATA_W must be 5..9");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t            state;
    logic [BW-1:0]     baud;
    logic [NW-1:0]     nbit;
    logic              sbit;
    logic [DATA_W-1:0] shift;
    logic              par_bit;
    logic              baud_end;

    assign baud_end         = (baud == BAUD_LAST);
    assign in_if.data_i_rdy = (state == IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            baud    <= '0;
            nbit    <= '0;
            sbit    <= 1'b0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                    baud   <= '0;
                    if (in_if.data_i_v) begin
                        // Parity is taken from the word as accepted; shift is consumed later.
                        shift   <= in_if.data_i;
                        par_bit <= (PARITY == 1) ? ~^in_if.data_i : ^in_if.data_i;
                        nbit    <= '0;
                        sbit    <= 1'b0;
                        state   <= START;
                        tx_o    <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= DATA;
                        tx_o  <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (nbit == BIT_LAST) begin
                            if (PARITY != 0) begin
                                state <= PAR;
                                tx_o  <= par_bit;
                            end else begin
                                state <= STOP;
                                tx_o  <= 1'b1;
                            end
                        end else begin
                            shift <= shift >> 1;
                            tx_o  <= shift[1];
                            nbit  <= nbit + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                PAR: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= STOP;
                        tx_o  <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    // Raised one cycle early so the registered pulse lands on the final cycle.
                    if (sbit == SBIT_LAST && baud == BAUD_PRE) done_o <= 1'b1;
                    if (baud_end) begin
                        baud <= '0;
                        if (sbit == SBIT_LAST) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            sbit <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                    baud   <= '0;
                end
            endcase
        end
    end
endmodule
